// File: rtl/alu_2_issuer.sv
// Initiator side of the type-2 ALU action interface: gathers operands from one PHV, issues a
// single action to the ALU, writes the result back into the destination container and emits the PHV.
module alu_2_issuer #(
  parameter int unsigned ACTION_LEN = 25,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_CONT   = 8,
  parameter int unsigned TIMEOUT    = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_CONT*DATA_WIDTH-1:0] phv_in,
  input  logic [ACTION_LEN-1:0]          action_word,
  input  logic                           phv_in_valid,
  output logic                           phv_in_ready,
  output logic [NUM_CONT*DATA_WIDTH-1:0] phv_out,
  output logic                           phv_out_valid,
  input  logic                           phv_out_ready,
  output logic [ACTION_LEN-1:0]          alu_action,
  output logic                           alu_action_valid,
  output logic [DATA_WIDTH-1:0]          alu_op1,
  output logic [DATA_WIDTH-1:0]          alu_op2,
  output logic [DATA_WIDTH-1:0]          alu_op3,
  input  logic [DATA_WIDTH-1:0]          alu_container,
  input  logic                           alu_container_valid,
  output logic                           timeout_err
);

  localparam int unsigned PhvW = NUM_CONT * DATA_WIDTH;
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StOut} state_e;

  state_e                state_q, state_d;
  logic [PhvW-1:0]       phv_q, phv_d;
  logic [ACTION_LEN-1:0] act_q, act_d;
  logic [DATA_WIDTH-1:0] op1_q, op1_d;
  logic [DATA_WIDTH-1:0] op2_q, op2_d;
  logic [DATA_WIDTH-1:0] op3_q, op3_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  to_q, to_d;

  logic [3:0]            in_opcode;
  logic [2:0]            in_dst;
  logic [2:0]            in_src2;
  logic [14:0]           in_imm;
  logic [2:0]            wb_dst;
  logic [DATA_WIDTH-1:0] in_dst_val;
  logic [DATA_WIDTH-1:0] in_src2_val;

  assign in_opcode = action_word[ACTION_LEN-1 -: 4];
  assign in_dst    = action_word[ACTION_LEN-5 -: 3];
  assign in_src2   = action_word[ACTION_LEN-8 -: 3];
  assign in_imm    = action_word[14:0];
  assign wb_dst    = act_q[ACTION_LEN-5 -: 3];

  always_comb begin
    in_dst_val  = '0;
    in_src2_val = '0;
    for (int unsigned i = 0; i < NUM_CONT; i++) begin
      if (32'(in_dst) == i) in_dst_val = phv_in[i*DATA_WIDTH +: DATA_WIDTH];
      if (32'(in_src2) == i) in_src2_val = phv_in[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    state_d = state_q;
    phv_d   = phv_q;
    act_d   = act_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    op3_d   = op3_q;
    cnt_d   = cnt_q;
    to_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (phv_in_valid) begin
          phv_d = phv_in;
          act_d = action_word;
          op1_d = in_dst_val;
          op3_d = in_dst_val;
          // Only register-register add/sub take op2 from a container.
          if (in_opcode == 4'b0001 || in_opcode == 4'b0010) op2_d = in_src2_val;
          else                                              op2_d = DATA_WIDTH'(in_imm);
          state_d = (in_opcode == 4'b0000) ? StOut : StIssue;
        end
      end
      StIssue: begin
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        cnt_d = cnt_q + CntW'(1);
        if (alu_container_valid) begin
          for (int unsigned i = 0; i < NUM_CONT; i++) begin
            if (32'(wb_dst) == i) phv_d[i*DATA_WIDTH +: DATA_WIDTH] = alu_container;
          end
          state_d = StOut;
        end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
          to_d    = 1'b1;
          state_d = StOut;
        end
      end
      StOut: begin
        if (phv_out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      phv_q   <= '0;
      act_q   <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      op3_q   <= '0;
      cnt_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      phv_q   <= phv_d;
      act_q   <= act_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      op3_q   <= op3_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
    end
  end

  assign phv_in_ready     = (state_q == StIdle);
  assign alu_action_valid = (state_q == StIssue);
  assign phv_out_valid    = (state_q == StOut);
  assign phv_out          = phv_q;
  assign alu_action       = act_q;
  assign alu_op1          = op1_q;
  assign alu_op2          = op2_q;
  assign alu_op3          = op3_q;
  assign timeout_err      = to_q;

endmodule

// File: tb/tb_alu_2_issuer.sv
// Scoreboard bench for alu_2_issuer with a 3-cycle ALU model that can be muted to force timeouts.
module tb_alu_2_issuer;

  localparam int AL = 25;
  localparam int DW = 32;
  localparam int NC = 8;
  localparam int TO = 8;
  localparam int PW = NC * DW;

  logic          clk;
  logic          rst_n;
  logic [PW-1:0] phv_in;
  logic [AL-1:0] action_word;
  logic          phv_in_valid;
  logic          phv_in_ready;
  logic [PW-1:0] phv_out;
  logic          phv_out_valid;
  logic          phv_out_ready;
  logic [AL-1:0] alu_action;
  logic          alu_action_valid;
  logic [DW-1:0] alu_op1, alu_op2, alu_op3;
  logic [DW-1:0] alu_container;
  logic          alu_container_valid;
  logic          timeout_err;

  logic          model_valid, stray_valid;
  logic [DW-1:0] model_data, stray_data;
  assign alu_container_valid = model_valid | stray_valid;
  assign alu_container       = stray_valid ? stray_data : model_data;

  alu_2_issuer #(
    .ACTION_LEN(AL), .DATA_WIDTH(DW), .NUM_CONT(NC), .TIMEOUT(TO)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .phv_in             (phv_in),
    .action_word        (action_word),
    .phv_in_valid       (phv_in_valid),
    .phv_in_ready       (phv_in_ready),
    .phv_out            (phv_out),
    .phv_out_valid      (phv_out_valid),
    .phv_out_ready      (phv_out_ready),
    .alu_action         (alu_action),
    .alu_action_valid   (alu_action_valid),
    .alu_op1            (alu_op1),
    .alu_op2            (alu_op2),
    .alu_op3            (alu_op3),
    .alu_container      (alu_container),
    .alu_container_valid(alu_container_valid),
    .timeout_err        (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct packed {
    logic [AL-1:0] act;
    logic [DW-1:0] op1;
    logic [DW-1:0] op2;
    logic [DW-1:0] op3;
  } ops_t;

  ops_t          ops_q[$];
  logic [PW-1:0] phv_q[$];

  function automatic logic [DW-1:0] cget(input logic [PW-1:0] p, input int i);
    return p[i*DW +: DW];
  endfunction

  function automatic logic [PW-1:0] cput(input logic [PW-1:0] p, input int i,
                                         input logic [DW-1:0] v);
    logic [PW-1:0] r;
    r = p;
    r[i*DW +: DW] = v;
    return r;
  endfunction

  function automatic logic [AL-1:0] mk(input logic [3:0] op, input logic [2:0] d,
                                       input logic [2:0] s, input logic [14:0] imm);
    return {op, d, s, imm};
  endfunction

  function automatic ops_t exp_ops(input logic [AL-1:0] aw, input logic [PW-1:0] p);
    ops_t o;
    o.act = aw;
    o.op1 = cget(p, int'(aw[20:18]));
    o.op3 = o.op1;
    if (aw[24:21] == 4'b0001 || aw[24:21] == 4'b0010) o.op2 = cget(p, int'(aw[17:15]));
    else                                              o.op2 = {17'd0, aw[14:0]};
    return o;
  endfunction

  // ALU model: samples the issue pulse, answers 3 cycles later unless muted.
  bit            alu_en;
  logic [DW-1:0] mem [32];
  initial begin
    ops_t          e;
    logic [DW-1:0] r;
    model_valid = 1'b0;
    model_data  = '0;
    forever begin
      @(negedge clk);
      if (alu_action_valid) begin
        if (ops_q.size() == 0) begin
          check("issue_unexpected", PW'(alu_action_valid), PW'(0));
        end else begin
          e = ops_q.pop_front();
          check("alu_action", PW'(alu_action), PW'(e.act));
          check("alu_op1", PW'(alu_op1), PW'(e.op1));
          check("alu_op2", PW'(alu_op2), PW'(e.op2));
          check("alu_op3", PW'(alu_op3), PW'(e.op3));
        end
        case (alu_action[24:21])
          4'b0001, 4'b1001: r = alu_op1 + alu_op2;
          4'b0010, 4'b1010: r = alu_op1 - alu_op2;
          4'b1000: begin
            mem[alu_op2[4:0]] = alu_op3;
            r = alu_op3;
          end
          4'b1011: r = mem[alu_op2[4:0]];
          default: r = '0;
        endcase
        if (alu_en) begin
          repeat (3) @(posedge clk);
          #1;
          model_valid = 1'b1;
          model_data  = r;
          @(posedge clk);
          #1;
          model_valid = 1'b0;
          model_data  = '0;
        end
      end
    end
  end

  int pulses = 0;
  int toerrs = 0;
  initial forever begin
    @(negedge clk);
    if (alu_action_valid) pulses++;
    if (timeout_err) toerrs++;
  end

  // Drives one PHV, then checks latency, result, backpressure hold and handshake.
  task automatic run(input string tag, input logic [PW-1:0] phv, input logic [AL-1:0] aw,
                     input logic [PW-1:0] exp, input int exp_lat, input bit exp_to,
                     input int hold);
    int            n;
    int            p0;
    int            t0;
    logic [PW-1:0] e;
    bit            is_nop;
    is_nop = (aw[24:21] == 4'b0000);
    p0 = pulses;
    t0 = toerrs;
    phv_q.push_back(exp);
    if (!is_nop) ops_q.push_back(exp_ops(aw, phv));
    phv_in       = phv;
    action_word  = aw;
    phv_in_valid = 1'b1;
    n = 0;
    while (!phv_in_ready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 50) check({tag, "_ready_wait"}, PW'(phv_in_ready), PW'(1));
    @(posedge clk);
    #1;
    phv_in_valid = 1'b0;
    n = 0;
    while (!phv_out_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_latency"}, PW'(n), PW'(exp_lat));
    check({tag, "_timeout_err"}, PW'(timeout_err), PW'(exp_to));
    e = phv_q.pop_front();
    check({tag, "_phv_out"}, phv_out, e);
    repeat (hold) begin
      @(posedge clk);
      #1;
      check({tag, "_hold_phv"}, phv_out, e);
      check({tag, "_hold_valid"}, PW'(phv_out_valid), PW'(1));
      check({tag, "_hold_in_ready"}, PW'(phv_in_ready), PW'(0));
    end
    phv_out_ready = 1'b1;
    @(posedge clk);
    #1;
    phv_out_ready = 1'b0;
    check({tag, "_valid_drop"}, PW'(phv_out_valid), PW'(0));
    check({tag, "_in_ready"}, PW'(phv_in_ready), PW'(1));
    check({tag, "_pulses"}, PW'(pulses - p0), PW'(is_nop ? 0 : 1));
    check({tag, "_toerr_pulses"}, PW'(toerrs - t0), PW'(exp_to));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [PW-1:0] base, p, x;
    logic [3:0]    op;
    logic [2:0]    d, s;
    logic [14:0]   imm;
    logic [DW-1:0] a, b;

    rst_n         = 1'b0;
    phv_in        = '0;
    action_word   = '0;
    phv_in_valid  = 1'b0;
    phv_out_ready = 1'b0;
    stray_valid   = 1'b0;
    stray_data    = '0;
    alu_en        = 1'b1;
    for (int i = 0; i < NC; i++) base[i*DW +: DW] = $urandom;

    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", PW'(phv_in_ready), PW'(1));
    check("rst_out_valid", PW'(phv_out_valid), PW'(0));
    check("rst_phv_out", phv_out, '0);
    check("rst_alu_valid", PW'(alu_action_valid), PW'(0));
    check("rst_alu_action", PW'(alu_action), PW'(0));
    check("rst_timeout", PW'(timeout_err), PW'(0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    p = cput(base, 3, 32'h10);
    run("addi", p, mk(4'b1001, 3'd3, 3'd0, 15'd5), cput(p, 3, 32'h15), 4, 1'b0, 0);

    p = cput(cput(base, 1, 32'd7), 2, 32'd9);
    run("add", p, mk(4'b0001, 3'd1, 3'd2, 15'h7fff), cput(p, 1, 32'd16), 4, 1'b0, 0);

    p = cput(cput(base, 1, 32'd3), 2, 32'd5);
    run("sub", p, mk(4'b0010, 3'd1, 3'd2, 15'd0), cput(p, 1, 32'hFFFFFFFE), 4, 1'b0, 0);

    p = cput(base, 0, 32'hCAFE);
    run("store", p, mk(4'b1000, 3'd0, 3'd7, 15'd4), p, 4, 1'b0, 0);
    run("load", base, mk(4'b1011, 3'd5, 3'd0, 15'd4), cput(base, 5, 32'hCAFE), 4, 1'b0, 0);

    // Stray ALU results in IDLE and OUT must not touch the PHV.
    stray_valid = 1'b1;
    stray_data  = 32'hDEADBEEF;
    run("nop", base, mk(4'b0000, 3'd4, 3'd1, 15'd9), base, 0, 1'b0, 5);
    stray_valid = 1'b0;

    alu_en = 1'b0;
    p = cput(base, 6, 32'h100);
    run("timeout", p, mk(4'b1001, 3'd6, 3'd0, 15'd3), p, TO + 1, 1'b1, 2);
    alu_en = 1'b1;

    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < NC; i++) p[i*DW +: DW] = $urandom;
      case ($urandom_range(0, 3))
        0:       op = 4'b0001;
        1:       op = 4'b0010;
        2:       op = 4'b1001;
        default: op = 4'b1010;
      endcase
      d   = 3'($urandom_range(0, 7));
      s   = 3'($urandom_range(0, 7));
      imm = 15'($urandom);
      a   = cget(p, int'(d));
      b   = (op == 4'b0001 || op == 4'b0010) ? cget(p, int'(s)) : {17'd0, imm};
      x   = cput(p, int'(d), op[1] ? a - b : a + b);
      run("rand", p, mk(op, d, s, imm), x, 4, 1'b0, k % 3);
    end

    // Reset while waiting on a muted ALU, then a late result arrives.
    alu_en = 1'b0;
    p = cput(base, 2, 32'h55);
    ops_q.push_back(exp_ops(mk(4'b1001, 3'd2, 3'd0, 15'd1), p));
    phv_in       = p;
    action_word  = mk(4'b1001, 3'd2, 3'd0, 15'd1);
    phv_in_valid = 1'b1;
    @(posedge clk);
    #1;
    phv_in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", PW'(phv_in_ready), PW'(1));
    check("midrst_out_valid", PW'(phv_out_valid), PW'(0));
    check("midrst_phv_out", phv_out, '0);
    check("midrst_alu_action", PW'(alu_action), PW'(0));
    check("midrst_op1", PW'(alu_op1), PW'(0));
    check("midrst_op2", PW'(alu_op2), PW'(0));
    @(posedge clk);
    #1;
    rst_n       = 1'b1;
    stray_valid = 1'b1;
    stray_data  = 32'h12345678;
    repeat (2) @(posedge clk);
    #1;
    stray_valid = 1'b0;
    check("late_out_valid", PW'(phv_out_valid), PW'(0));
    check("late_phv_out", phv_out, '0);
    check("late_in_ready", PW'(phv_in_ready), PW'(1));
    alu_en = 1'b1;

    p = cput(base, 7, 32'hFFFFFFFF);
    run("post_rst", p, mk(4'b1001, 3'd7, 3'd0, 15'd2), cput(p, 7, 32'd1), 4, 1'b0, 0);

    check("scoreboard_empty", PW'(phv_q.size() + ops_q.size()), PW'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
